data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 195 +++++++++++++++++++
 tb/tb_data_cache.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Optional hit/miss statistics counters are compiled in with `define DCACHE_STATS_EN.
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_BITS-1:0]     tag_q  [LINES];
  logic [DATA_WIDTH-1:0]   data_q [LINES];
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  logic [INDEX_BITS-1:0]   idx_s;
  logic [TAG_BITS-1:0]     tag_s;
  logic [DATA_WIDTH-1:0]   word_addr_s;
  logic                    hit_s;
  logic                    line_wr_s;
  logic [DATA_WIDTH-1:0]   line_wdata_s;
  logic                    unused_s;

`ifdef DCACHE_STATS_EN
  logic [31:0]             hit_count_q, hit_count_d;
  logic [31:0]             miss_count_q, miss_count_d;
  logic                    fill_done_q, fill_done_d;
`endif

  assign idx_s       = cpu_addr[INDEX_BITS+1:2];
  assign tag_s       = cpu_addr[DATA_WIDTH-1:INDEX_BITS+2];
  assign word_addr_s = {cpu_addr[DATA_WIDTH-1:2], 2'b00};
  assign unused_s    = ^cpu_addr[1:0];
  // A line being reset is treated as already invalid so no stale data escapes.
  assign hit_s       = cpu_req & ~rst & valid_q[idx_s] & (tag_q[idx_s] == tag_s);

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Next-state, memory-request and CPU response decode.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    line_wr_s    = 1'b0;
    line_wdata_s = cpu_wdata;
    cpu_stall    = 1'b0;
    cpu_rdata    = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req && cpu_we) begin
          cpu_stall   = 1'b1;
          state_d     = WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = word_addr_s;
          mem_wdata_d = cpu_wdata;
        end else if (cpu_req && !hit_s) begin
          cpu_stall   = 1'b1;
          state_d     = FILL;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = word_addr_s;
          mem_wdata_d = '0;
        end else if (hit_s) begin
          cpu_rdata = data_q[idx_s];
        end else begin
          cpu_stall = 1'b0;
        end
      end
      FILL: begin
        cpu_stall = 1'b1;
        if (mem_ack) begin
          line_wr_s      = 1'b1;
          line_wdata_s   = mem_rdata;
          valid_d[idx_s] = 1'b1;
          state_d        = IDLE;
          mem_req_d      = 1'b0;
          mem_we_d       = 1'b0;
        end else begin
          line_wr_s = 1'b0;
        end
      end
      WRITE: begin
        cpu_stall = ~mem_ack;
        if (mem_ack) begin
          // Write-through: only an already-resident line is refreshed.
          line_wr_s    = hit_s;
          line_wdata_s = cpu_wdata;
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
        end else begin
          line_wr_s = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

`ifdef DCACHE_STATS_EN
  // Statistics: the load re-presented right after a fill completes a miss, not a hit.
  always_comb begin
    fill_done_d  = (state_q == FILL) && mem_ack;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if ((state_q == IDLE) && hit_s && !cpu_we && !fill_done_q) begin
      hit_count_d = hit_count_q + 32'd1;
    end else begin
      hit_count_d = hit_count_q;
    end
    if ((state_q == IDLE) && cpu_req && !cpu_we && !hit_s) begin
      miss_count_d = miss_count_q + 32'd1;
    end else begin
      miss_count_d = miss_count_q;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  // State, valid bits, memory request registers and line array.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef DCACHE_STATS_EN
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
      fill_done_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef DCACHE_STATS_EN
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      fill_done_q  <= fill_done_d;
`endif
      if (line_wr_s) begin
        tag_q[idx_s]  <= tag_s;
        data_q[idx_s] <= line_wdata_s;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed vector table, reset corner cases,
// and randomized accesses checked against a line-level reference model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst, cpu_req, cpu_we, mem_ack;
  logic        cpu_stall, mem_req, mem_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: which word address each line holds and its data.
  bit          m_valid [16];
  logic [29:0] m_word  [16];
  logic [31:0] m_data  [16];
  int          exp_hits = 0;
  int          exp_misses = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;
    logic [31:0] mdata;
    logic        exp_stall0;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  data_cache dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // One cycle with no CPU request; optionally a stray mem_ack.
  task automatic idle_cycle(input logic stray_ack);
    @(posedge clk); #1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    mem_ack   = stray_ack;
    mem_rdata = $urandom;
    @(negedge clk);
    chk1("idle_stall", cpu_stall, 1'b0);
    chk32("idle_rdata", cpu_rdata, 32'd0);
    chk1("idle_mem_req", mem_req, 1'b0);
  endtask

  // Full CPU access; memory acks on the ack_at-th cycle of its request.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_at, input logic [31:0] mdata,
                           output logic stall0, output logic [31:0] rdata_last);
    int          idx;
    bit          hit;
    logic [31:0] waddr;
    idx   = int'(addr[5:2]);
    waddr = addr & 32'hFFFF_FFFC;
    hit   = m_valid[idx] && (m_word[idx] == addr[31:2]);
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    @(negedge clk);
    stall0     = cpu_stall;
    rdata_last = cpu_rdata;
    chk1("first_mem_req", mem_req, 1'b0);
    if (!we && hit) begin
      exp_hits++;
      chk1("hit_stall", cpu_stall, 1'b0);
      chk32("hit_rdata", cpu_rdata, m_data[idx]);
    end else begin
      chk1("access_stall", cpu_stall, 1'b1);
      if (!we) exp_misses++;
      for (int j = 1; j <= ack_at; j++) begin
        @(posedge clk); #1;
        mem_ack   = (j == ack_at);
        mem_rdata = (j == ack_at) ? mdata : $urandom;
        @(negedge clk);
        chk1("mem_req", mem_req, 1'b1);
        chk1("mem_we", mem_we, we);
        chk32("mem_addr", mem_addr, waddr);
        if (we) chk32("mem_wdata", mem_wdata, wdata);
        chk1("xfer_stall", cpu_stall, !(we && (j == ack_at)));
        rdata_last = cpu_rdata;
      end
      if (we) begin
        if (hit) m_data[idx] = wdata;
      end else begin
        m_valid[idx] = 1'b1;
        m_word[idx]  = addr[31:2];
        m_data[idx]  = mdata;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        @(negedge clk);
        rdata_last = cpu_rdata;
        chk1("refill_stall", cpu_stall, 1'b0);
        chk32("refill_rdata", cpu_rdata, mdata);
        chk1("refill_mem_req", mem_req, 1'b0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s0;
    logic [31:0] rd;
    logic [31:0] a;
    int          r;

    vecs[0]  = '{1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0, 1, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0080, 32'h0, 2, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
    vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h0000_0080, 32'h0, 1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
    vecs[5]  = '{1'b1, 32'h0000_0080, 32'h1234_5678, 3, 32'h0, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0080, 32'h0, 1, 32'h0,         1'b0, 32'h1234_5678};
    vecs[7]  = '{1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 2, 32'h0, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0100, 32'h0, 1, 32'h5A5A_5A5A, 1'b1, 32'h5A5A_5A5A};
    vecs[9]  = '{1'b0, 32'h0000_007C, 32'h0, 4, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D};
    vecs[10] = '{1'b0, 32'h0000_007E, 32'h0, 1, 32'h0,         1'b0, 32'h0BAD_F00D};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 1, 32'h1357_9BDF, 1'b1, 32'h1357_9BDF};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_stall", cpu_stall, 1'b0);
    chk32("rst_rdata", cpu_rdata, 32'd0);
    rst = 1'b0;

    idle_cycle(1'b1);
    idle_cycle(1'b0);

    for (int i = 0; i < 12; i++) begin
      do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ack_at, vecs[i].mdata, s0, rd);
      chk1($sformatf("vec%0d_stall0", i), s0, vecs[i].exp_stall0);
      chk32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
`ifdef DCACHE_STATS_EN
      if (i == 3) begin
        chk32("stats_miss", miss_count, 32'd3);
        chk32("stats_hit", hit_count, 32'd1);
      end
`endif
    end

    // Reset in the second FILL cycle, then a late ack that must be ignored.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0200; mem_ack = 1'b0;
    @(negedge clk);
    chk1("abort_stall", cpu_stall, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("abort_fill1_req", mem_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk1("abort_mem_req", mem_req, 1'b0);
    chk1("abort_mem_we", mem_we, 1'b0);
    chk1("abort_idle_stall", cpu_stall, 1'b0);
    chk32("abort_rdata", cpu_rdata, 32'd0);
    clear_model();
    idle_cycle(1'b0);
    chk1("abort_still_idle", mem_req, 1'b0);
    do_access(1'b0, 32'h0000_0200, 32'h0, 2, 32'h2222_0200, s0, rd);
    chk1("post_rst_miss_200", s0, 1'b1);
    do_access(1'b0, 32'h0000_0100, 32'h0, 1, 32'h3333_0100, s0, rd);
    chk1("post_rst_miss_100", s0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        idle_cycle(1'($urandom_range(0, 1)));
      end else begin
        a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
            32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
        do_access(r < 4, a, $urandom, $urandom_range(1, 4), $urandom, s0, rd);
      end
    end

`ifdef DCACHE_STATS_EN
    @(negedge clk);
    chk32("final_hits", hit_count, 32'(exp_hits));
    chk32("final_misses", miss_count, 32'(exp_misses));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
